// File: rtl/tqvp_adder_mc_pkg.sv
// Shared constants for the multi-cycle adder peripheral: register map, MODE codes,
// STATUS bit positions and FSM state encodings.
package tqvp_adder_mc_pkg;

  localparam logic [5:0] ADDR_OPA    = 6'h00;
  localparam logic [5:0] ADDR_OPB    = 6'h04;
  localparam logic [5:0] ADDR_CTRL   = 6'h08;
  localparam logic [5:0] ADDR_STATUS = 6'h0C;
  localparam logic [5:0] ADDR_RESULT = 6'h10;

  localparam int CTRL_START    = 0;
  localparam int CTRL_SAT_MODE = 3;
  localparam int STATUS_CLR    = 1;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_CARRY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_SAT   = 4;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Byte-lane mask selected by the active-low access-size code (11 = no access).
  function automatic logic [31:0] lane_mask(input logic [1:0] size_n);
    case (size_n)
      2'b00:   lane_mask = 32'h0000_00FF;
      2'b01:   lane_mask = 32'h0000_FFFF;
      2'b10:   lane_mask = 32'hFFFF_FFFF;
      default: lane_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_adder_mc_slice.sv
// CHUNK-bit ripple adder slice; the top reuses this one instance on every RUN cycle.
module tqvp_adder_mc_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/tqvp_adder_mc.sv
// Multi-cycle ADD/SUB/ACC peripheral processing CHUNK bits per clock, LSB first.
// Optional saturation is enabled by defining TQVP_ADDER_MC_SAT_EN.
module tqvp_adder_mc
  import tqvp_adder_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(NCHUNK + 1);

  state_e state_q, state_d;
  logic   busy, done;

  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [WIDTH-1:0] op_a_q, op_b_q, sum_q, sum_next;
  logic [CNT_W-1:0] cnt_q;
  mode_e            mode_q, mode_sel;
  logic             carry_q, a_msb_q, b_msb_q;
  logic             flag_carry_q, flag_carry_d, flag_ovf_q, flag_ovf_d;
  logic             flag_sat_q, flag_sat_d, irq_q, irq_d;

  logic             wr_en, cfg_wr_ok, start, irq_clr, done_entry;
  logic [31:0]      wr_mask, wr_opa, wr_opb, status_w;
  logic [WIDTH-1:0] run_a, run_b, res_fin;
  logic             run_cin, carry_fin, ovf_fin, sat_fin;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;

`ifdef TQVP_ADDER_MC_SAT_EN
  logic sat_mode_q;
`endif

  // Config registers are frozen while a computation is in flight.
  assign wr_en      = (data_write_n != 2'b11);
  assign wr_mask    = lane_mask(data_write_n);
  assign cfg_wr_ok  = wr_en && !busy;
  assign start      = cfg_wr_ok && (address == ADDR_CTRL) && data_in[CTRL_START];
  assign irq_clr    = wr_en && (address == ADDR_STATUS) && data_in[STATUS_CLR];
  assign done_entry = busy && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN:          if (cnt_q == '0) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  tqvp_adder_mc_slice #(.CHUNK(CHUNK)) u_slice (
    .a_i    (op_a_q[CHUNK-1:0]),
    .b_i    (op_b_q[CHUNK-1:0]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Each new chunk enters at the top so the full sum is aligned after NCHUNK shifts.
  assign sum_next = (sum_q >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));

  always_comb begin
    mode_sel = mode_e'(data_in[2:1]);
    if (mode_sel == MODE_RSVD) mode_sel = MODE_ADD;
    run_a   = opa_q;
    run_b   = opb_q;
    run_cin = 1'b0;
    case (mode_sel)
      MODE_SUB: begin
        run_b   = ~opb_q;
        run_cin = 1'b1;
      end
      MODE_ACC: begin
        run_a = result_q;
        run_b = opa_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_ADD;
    end else if (start) begin
      op_a_q  <= run_a;
      op_b_q  <= run_b;
      sum_q   <= '0;
      carry_q <= run_cin;
      a_msb_q <= run_a[WIDTH-1];
      b_msb_q <= run_b[WIDTH-1];
      cnt_q   <= CNT_W'(NCHUNK - 1);
      mode_q  <= mode_sel;
    end else if (busy) begin
      op_a_q  <= op_a_q >> CHUNK;
      op_b_q  <= op_b_q >> CHUNK;
      sum_q   <= sum_next;
      carry_q <= slice_cout;
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

`ifdef TQVP_ADDER_MC_SAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)     sat_mode_q <= 1'b0;
    else if (start) sat_mode_q <= data_in[CTRL_SAT_MODE];
  end
`endif

  // SUB reports borrow, which is the inverse of the adder carry-out.
  always_comb begin
    carry_fin = (mode_q == MODE_SUB) ? ~slice_cout : slice_cout;
    ovf_fin   = (a_msb_q == b_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
    res_fin   = sum_next;
    sat_fin   = 1'b0;
`ifdef TQVP_ADDER_MC_SAT_EN
    if (sat_mode_q && carry_fin) begin
      sat_fin = 1'b1;
      res_fin = (mode_q == MODE_SUB) ? '0 : '1;
    end
`endif
  end

  assign wr_opa = (32'(opa_q) & ~wr_mask) | (data_in & wr_mask);
  assign wr_opb = (32'(opb_q) & ~wr_mask) | (data_in & wr_mask);

  always_comb begin
    opa_d        = opa_q;
    opb_d        = opb_q;
    result_d     = result_q;
    flag_carry_d = flag_carry_q;
    flag_ovf_d   = flag_ovf_q;
    flag_sat_d   = flag_sat_q;
    irq_d        = irq_q;
    if (cfg_wr_ok && (address == ADDR_OPA)) opa_d = wr_opa[WIDTH-1:0];
    if (cfg_wr_ok && (address == ADDR_OPB)) opb_d = wr_opb[WIDTH-1:0];
    if (done_entry) begin
      result_d     = res_fin;
      flag_carry_d = carry_fin;
      flag_ovf_d   = ovf_fin;
      flag_sat_d   = sat_fin;
    end
    // Set has priority over a coincident clear.
    if (irq_clr || start) irq_d = 1'b0;
    if (done_entry)       irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa_q        <= '0;
      opb_q        <= '0;
      result_q     <= '0;
      flag_carry_q <= 1'b0;
      flag_ovf_q   <= 1'b0;
      flag_sat_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      result_q     <= result_d;
      flag_carry_q <= flag_carry_d;
      flag_ovf_q   <= flag_ovf_d;
      flag_sat_q   <= flag_sat_d;
      irq_q        <= irq_d;
    end
  end

  always_comb begin
    status_w           = '0;
    status_w[ST_BUSY]  = busy;
    status_w[ST_DONE]  = done;
    status_w[ST_CARRY] = flag_carry_q;
    status_w[ST_OVF]   = flag_ovf_q;
    status_w[ST_SAT]   = flag_sat_q;
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_OPA:    data_out = 32'(opa_q);
      ADDR_OPB:    data_out = 32'(opb_q);
      ADDR_STATUS: data_out = status_w;
      ADDR_RESULT: data_out = 32'(result_q);
      default:     ;
    endcase
  end

  assign data_ready     = 1'b1;
  assign user_interrupt = irq_q;
  assign uo_out = {ui_in[7:5] ^ result_q[2:0], flag_ovf_q, flag_carry_q, done, busy, irq_q};

  logic unused_ok;
  assign unused_ok = ^{data_read_n, ui_in[4:0], wr_opa, wr_opb};

endmodule

// File: tb/tb_tqvp_adder_mc.sv
// Directed bench for tqvp_adder_mc: a 32/8 instance plus a 16/1 instance sharing one bus.
module tb_tqvp_adder_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n, data_read_n;
  logic [7:0]  uo_out, uo16;
  logic [31:0] dout, dout16;
  logic        drdy, drdy16, irq, irq16;

  int passed = 0;
  int total  = 0;

  always #10 clk = ~clk;

  tqvp_adder_mc #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(dout), .data_ready(drdy),
    .user_interrupt(irq)
  );

  tqvp_adder_mc #(.WIDTH(16), .CHUNK(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo16),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(dout16), .data_ready(drdy16),
    .user_interrupt(irq16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    address      = a;
    data_in      = d;
    data_write_n = sz;
    @(posedge clk);
    #1;
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d, output logic [31:0] d16);
    address     = a;
    data_read_n = 2'b10;
    #1;
    d           = dout;
    d16         = dout16;
    data_read_n = 2'b11;
  endtask

  task automatic wait_done(output int c32, output int c16);
    c32 = 0;
    c16 = 0;
    for (int i = 0; i < 300; i++) begin
      if (!(uo_out[1] || uo16[1])) break;
      if (uo_out[1]) c32++;
      if (uo16[1])   c16++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, r16;
    int c32, c16;

    ui_in        = 8'hA5;
    address      = 6'h00;
    data_in      = 32'h0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uo_out", {24'h0, uo_out}, 32'hA0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(6'h10, r, r16); chk("rst_result", r, 32'h0);
    rd(6'h0C, r, r16); chk("rst_status", r, 32'h0);
    rd(6'h00, r, r16); chk("rst_opa", r, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("data_ready", {31'h0, drdy}, 32'h1);

    // 0xFFFFFFFF + 1 on both widths (16-bit instance sees 0xFFFF + 1)
    wr(6'h00, 32'hFFFF_FFFF, 2'b10);
    wr(6'h04, 32'h0000_0001, 2'b10);
    wr(6'h08, 32'h1, 2'b10);
    wait_done(c32, c16);
    chk("busy_cycles_32x8", c32, 4);
    chk("busy_cycles_16x1", c16, 16);
    rd(6'h10, r, r16);
    chk("add_wrap_result", r, 32'h0);
    chk("add16_wrap_result", r16, 32'h0);
    rd(6'h0C, r, r16);
    chk("add_wrap_status", r, 32'h06);
    chk("add16_wrap_status", r16, 32'h06);
    chk("add_irq", {31'h0, irq}, 32'h1);
    chk("add_uo_out", {24'h0, uo_out}, 32'hAD);

    // 5 - 7: RESULT holds old value during RUN, then borrow
    wr(6'h00, 32'h5, 2'b10);
    wr(6'h04, 32'h7, 2'b10);
    wr(6'h08, 32'h3, 2'b10);
    rd(6'h10, r, r16);
    chk("sub_result_hold_in_run", r, 32'h0);
    chk("sub_busy_in_run", {31'h0, uo_out[1]}, 32'h1);
    chk("start_clears_irq", {31'h0, irq}, 32'h0);
    wait_done(c32, c16);
    rd(6'h10, r, r16); chk("sub_borrow_result", r, 32'hFFFF_FFFE);
    rd(6'h0C, r, r16); chk("sub_borrow_status", r, 32'h06);

    // 0x80000000 - 1: signed overflow, no borrow
    wr(6'h00, 32'h8000_0000, 2'b10);
    wr(6'h04, 32'h1, 2'b10);
    wr(6'h08, 32'h3, 2'b10);
    wait_done(c32, c16);
    rd(6'h10, r, r16); chk("sub_ovf_result", r, 32'h7FFF_FFFF);
    rd(6'h0C, r, r16); chk("sub_ovf_status", r, 32'h0A);

    wr(6'h0C, 32'h2, 2'b10);
    chk("irq_clear", {31'h0, irq}, 32'h0);
    chk("ovf_uo_out", {24'h0, uo_out}, 32'h54);

    // Reset during the second RUN cycle aborts the operation
    wr(6'h00, 32'h3, 2'b10);
    wr(6'h04, 32'h4, 2'b10);
    wr(6'h08, 32'h1, 2'b10);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rd(6'h10, r, r16); chk("abort_result", r, 32'h0);
    rd(6'h0C, r, r16); chk("abort_status", r, 32'h0);
    chk("abort_irq", {31'h0, irq}, 32'h0);

    // ACC three times from RESULT=0; OPA write during RUN is dropped
    wr(6'h00, 32'h10, 2'b10);
    wr(6'h08, 32'h5, 2'b10);
    wr(6'h00, 32'h100, 2'b10);
    wait_done(c32, c16);
    wr(6'h08, 32'h5, 2'b10);
    wait_done(c32, c16);
    wr(6'h08, 32'h5, 2'b10);
    wait_done(c32, c16);
    rd(6'h10, r, r16); chk("acc_result", r, 32'h30);
    rd(6'h00, r, r16); chk("opa_write_in_run_ignored", r, 32'h10);
    rd(6'h0C, r, r16); chk("acc_status", r, 32'h02);

    // SAT_MODE request with a carry out
    wr(6'h00, 32'hFFFF_FFF0, 2'b10);
    wr(6'h04, 32'h20, 2'b10);
    wr(6'h08, 32'h9, 2'b10);
    wait_done(c32, c16);
    rd(6'h10, r, r16);
`ifdef TQVP_ADDER_MC_SAT_EN
    chk("sat_result", r, 32'hFFFF_FFFF);
    rd(6'h0C, r, r16); chk("sat_status", r, 32'h16);
`else
    chk("sat_result", r, 32'h10);
    rd(6'h0C, r, r16); chk("sat_status", r, 32'h06);
`endif

    // IRQ clear landing on the DONE-entry edge: set wins
    wr(6'h00, 32'h1, 2'b10);
    wr(6'h04, 32'h1, 2'b10);
    wr(6'h08, 32'h1, 2'b10);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    wr(6'h0C, 32'h2, 2'b10);
    chk("irq_set_wins", {31'h0, irq}, 32'h1);
    rd(6'h0C, r, r16); chk("set_wins_status", r, 32'h02);
    rd(6'h10, r, r16); chk("set_wins_result", r, 32'h2);
    wait_done(c32, c16);

    // Byte-lane writes and unmapped read
    wr(6'h00, 32'hFFFF_FFFF, 2'b10);
    wr(6'h00, 32'h1234_5678, 2'b00);
    rd(6'h00, r, r16);
    chk("opa_8b_write", r, 32'hFFFF_FF78);
    chk("opa16_8b_write", r16, 32'h0000_FF78);
    wr(6'h00, 32'hAAAA_5555, 2'b01);
    rd(6'h00, r, r16);
    chk("opa_16b_write", r, 32'hFFFF_5555);
    chk("opa16_16b_write", r16, 32'h0000_5555);
    rd(6'h14, r, r16); chk("unmapped_read", r, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tqvp_adder_mc.md
TQVP_ADDER_MC -- requirements
Module: tqvp_adder_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (8..32, multiple of CHUNK).
REQ-002 SHALL have parameter CHUNK, default 8, bits added per clock (1, 2, 4, 8, 16 or 32).
REQ-003 SHALL have port clk  input  1  clock; rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ui_in  input  8  PMOD in; uo_out  output  8  status PMOD.
REQ-005 SHALL have address  input  6  register select; data_in  input  32  write data.
REQ-006 SHALL have data_write_n  input  2  (11 none, 00 8b, 01 16b, 10 32b); data_read_n  input  2  same encoding.
REQ-007 SHALL have data_out  output  32  read data; data_ready  output  1  read valid; user_interrupt  output  1  done IRQ.

Function
REQ-008 Register map: 0x00 OPA, 0x04 OPB, 0x08 CTRL, 0x0C STATUS, 0x10 RESULT; other addresses read 0, writes ignored.
REQ-009 OPA/OPB SHALL honour byte lanes per data_write_n; bits above WIDTH read 0.
REQ-010 CTRL write: bit0 START, bits2:1 MODE (00 ADD, 01 SUB, 10 ACC = RESULT+OPA, 11 reserved = ADD).
REQ-011 FSM states IDLE, RUN, DONE; IDLE/DONE + START -> RUN, latching MODE and both operands.
REQ-012 RUN SHALL process CHUNK bits per cycle, LSB first, with carry held between chunks; exactly WIDTH/CHUNK cycles, then -> DONE.
REQ-013 SUB SHALL compute OPA + ~OPB + 1; STATUS.CARRY = 1 means borrow (OPA < OPB unsigned).
REQ-014 RESULT SHALL update only at the RUN->DONE transition; it holds the previous value while RUN.
REQ-015 STATUS read: bit0 BUSY (RUN), bit1 DONE, bit2 CARRY, bit3 OVF (signed overflow), bit4 SAT (saturated).
REQ-016 Writes to OPA, OPB, CTRL during RUN SHALL be ignored; START in RUN has no effect.
REQ-017 Entering DONE SHALL set user_interrupt; it clears on a STATUS write with data_in[1]=1, or on START.
REQ-018 Same-cycle DONE entry and clear write: set wins.
REQ-019 data_ready SHALL be 1 always; reads are combinational, 1 cycle; data_read_n is otherwise unused.
REQ-020 uo_out = {ui_in[7:5] ^ RESULT[2:0], OVF, CARRY, DONE, BUSY, user_interrupt} (MSB to LSB).
REQ-021 ACC mode in RUN SHALL use the RESULT value latched at START, not partial sums.

Reset
REQ-022 rst_n low SHALL put the FSM in IDLE and clear OPA, OPB, RESULT, MODE, all STATUS bits and user_interrupt; uo_out = {ui_in[7:5], 5'b0}.
REQ-023 Reset asserted in RUN SHALL abort; RESULT stays 0, no interrupt.

Configuration
REQ-024 With TQVP_ADDER_MC_SAT_EN defined, CTRL bit3 SAT_MODE SHALL clamp ADD/ACC to all-ones on carry and SUB to 0 on borrow, setting STATUS.SAT.
REQ-025 Without TQVP_ADDER_MC_SAT_EN, CTRL bit3 SHALL be ignored, results wrap modulo 2^WIDTH and STATUS.SAT reads 0.

Structure
REQ-026 Package tqvp_adder_mc_pkg SHALL hold register address constants, MODE encodings, STATUS bit indices and FSM state encodings.
REQ-027 Sub-module tqvp_adder_mc_slice: CHUNK-bit adder with carry-in/out, instantiated once and reused every cycle.

Verification
REQ-028 WIDTH=32, CHUNK=8: OPA=0xFFFFFFFF, OPB=1, CTRL=0x1 -> BUSY exactly 4 cycles, RESULT=0, CARRY=1, OVF=0, IRQ=1.
REQ-029 OPA=5, OPB=7, CTRL=0x3 (SUB) -> RESULT=0xFFFFFFFE, CARRY=1; OPA=0x80000000, OPB=1 SUB -> OVF=1.
REQ-030 RESULT=0 then ACC START three times with OPA=0x10 -> RESULT=0x30; OPA write during RUN discarded.
REQ-031 SAT_EN defined, CTRL=0x9, OPA=0xFFFFFFF0, OPB=0x20 -> RESULT=0xFFFFFFFF, SAT=1; undefined -> RESULT=0x10, SAT=0.
REQ-032 rst_n low in 2nd RUN cycle -> IDLE, RESULT=0, no IRQ; IRQ clear write coincident with DONE entry -> IRQ stays 1.
REQ-033 WIDTH=16, CHUNK=1 -> BUSY exactly 16 cycles; 0xFFFF+0x0001 -> RESULT=0, CARRY=1.
